// File: rtl/rd_stream_adapter.sv
// Read-side output stage of the async FIFO: prefetches popped words into a small
// in-order buffer and presents them as a registered valid/ready stream.
module rd_stream_adapter #(
    parameter int DSIZE   = 8,
    parameter int RAM_REG = 0
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    output logic             rinc,
    input  logic [DSIZE-1:0] rdata,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic [1:0]       buf_cnt
);

    localparam int OBUF_DEPTH = 2 + RAM_REG;
    localparam int IW         = $clog2(OBUF_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(OBUF_DEPTH - 1);
    localparam logic [1:0]    DEPTH2   = 2'(OBUF_DEPTH);
    localparam logic [2:0]    DEPTH3   = 3'(OBUF_DEPTH);

    logic [DSIZE-1:0] entry [OBUF_DEPTH];
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic [1:0]       count;
    logic             inflight;
    logic             capture;
    logic             drain;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // Reserve a slot for the in-flight word so a pop is never issued without room.
    assign rinc    = rrst_n && !rempty && (({1'b0, count} + {2'b00, inflight}) < DEPTH3);
    assign capture = (RAM_REG != 0) ? inflight : rinc;
    assign drain   = m_valid && m_ready;

    assign m_valid = (count != 2'd0);
    assign m_data  = entry[rd_idx];
    assign buf_cnt = count;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= (RAM_REG != 0) && rinc;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= 2'd0;
        end else begin
            if (capture) begin
                wr_idx <= next_idx(wr_idx);
            end
            if (drain) begin
                rd_idx <= next_idx(rd_idx);
            end
            case ({capture, drain})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (capture) begin
            entry[wr_idx] <= rdata;
        end
    end

    a_count_range: assert property (@(posedge rclk) disable iff (!rrst_n)
        count <= DEPTH2);
    a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n)
        !(capture && !drain && (count == DEPTH2)));

endmodule
